// File: rtl/vector_writeback_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vector_writeback_pkg
// Purpose  : Shared defaults and FSM state encoding for the vector writeback.
// Revision : 1.0 - initial release
// ============================================================================
package vector_writeback_pkg;

    localparam int VW_REG_LEN    = 64;
    localparam int VW_NUM_REGS   = 8;
    localparam int VW_ELEM_SIZE  = 8;
    localparam int VW_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_result_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_result_fifo
// Purpose  : In-order result queue; power-of-two depth so pointers wrap freely.
// Revision : 1.0 - initial release
// ============================================================================
module wb_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign rdata     = mem_q[rd_ptr_q];
    // A full queue refuses a push even if the head leaves in the same cycle.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        if (w_do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vector_writeback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vector_writeback
// Purpose  : Queues execute results and commits them to the vector register
//            file, merging partial-lane writes with the current register value.
// Revision : 1.0 - initial release
// ============================================================================
module vector_writeback
    import vector_writeback_pkg::*;
#(
    parameter int REG_LEN    = VW_REG_LEN,
    parameter int NUM_REGS   = VW_NUM_REGS,
    parameter int ELEM_SIZE  = VW_ELEM_SIZE,
    parameter int FIFO_DEPTH = VW_FIFO_DEPTH,
    localparam int ADDR_W    = $clog2(NUM_REGS),
    localparam int NUM_LANES = REG_LEN / ELEM_SIZE
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [REG_LEN-1:0]   in_data,
    input  logic [NUM_LANES-1:0] in_lane_mask,
    output logic [ADDR_W-1:0]    rf_read_addr,
    output logic [NUM_LANES-1:0] rf_read_en,
    input  logic [REG_LEN-1:0]   rf_read_data,
    output logic [ADDR_W-1:0]    rf_write_addr,
    output logic                 rf_write_en,
    output logic [REG_LEN-1:0]   rf_write_data,
    output logic                 wb_done,
    output logic                 wb_drop,
    output logic                 busy
);

    localparam int ENTRY_W = ADDR_W + NUM_LANES + REG_LEN;

    wb_state_t            state_q, state_d;
    logic [REG_LEN-1:0]   cap_q, cap_d;

    logic [ENTRY_W-1:0]   w_fifo_wdata;
    logic [ENTRY_W-1:0]   w_fifo_rdata;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pop;
    logic [ADDR_W-1:0]    w_head_addr;
    logic [NUM_LANES-1:0] w_head_mask;
    logic [REG_LEN-1:0]   w_head_data;
    logic [REG_LEN-1:0]   w_merged;

    assign w_fifo_wdata = {in_addr, in_lane_mask, in_data};
    assign {w_head_addr, w_head_mask, w_head_data} = w_fifo_rdata;

    wb_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (in_valid),
        .wdata  (w_fifo_wdata),
        .pop    (w_pop),
        .rdata  (w_fifo_rdata),
        .full   (w_fifo_full),
        .empty  (w_fifo_empty)
    );

    assign in_ready = !w_fifo_full;
    assign busy     = !w_fifo_empty || (state_q != ST_IDLE);

    // Enabled lanes take the new result, the rest keep the register contents.
    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            assign w_merged[i*ELEM_SIZE +: ELEM_SIZE] = w_head_mask[i]
                ? w_head_data[i*ELEM_SIZE +: ELEM_SIZE]
                : rf_read_data[i*ELEM_SIZE +: ELEM_SIZE];
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        cap_d         = cap_q;
        w_pop         = 1'b0;
        rf_read_addr  = '0;
        rf_read_en    = '0;
        rf_write_addr = '0;
        rf_write_en   = 1'b0;
        rf_write_data = '0;
        wb_done       = 1'b0;
        wb_drop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    // Register 0 is hardwired; an empty mask has nothing to write.
                    if ((w_head_addr == '0) || (w_head_mask == '0)) begin
                        w_pop   = 1'b1;
                        wb_drop = 1'b1;
                    end else if (&w_head_mask) begin
                        cap_d   = w_head_data;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                rf_read_addr = w_head_addr;
                rf_read_en   = '1;
                cap_d        = w_merged;
                state_d      = ST_WRITE;
            end
            ST_WRITE: begin
                rf_write_en   = 1'b1;
                rf_write_addr = w_head_addr;
                rf_write_data = cap_q;
                w_pop         = 1'b1;
                wb_done       = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
        end
    end

endmodule
`default_nettype wire
